l2_axi_bridge: RTL and testbench

Downstream memory-side stage of the cache hierarchy. Consumes the unified L2 cache's external block port (subblock-serialised block reads/writes, strobe-indexed) and converts each request into one AXI4 INCR burst on a master port toward DRAM/interconnect. Buffers one full block for writes, streams read beats straight back to the L2, and reports completion via readyD. One outstanding request at a time.

---
 rtl/l2_axi_bridge_if.sv | 60 ++++++
 rtl/l2_axi_bridge.sv | 256 +++++++++++++++++++++++++
 tb/tb_l2_axi_bridge.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_axi_bridge_if.sv
// AXI4 master-side bundle between l2_axi_bridge and the DRAM/interconnect.
// Carries the AR/R/AW/W/B channels. Data width is one L2 subblock.
//   master : bridge side (drives addresses, write data, rready/bready)
//   slave  : memory side (drives readies, read data, responses)
interface l2_axi_bridge_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 128
);
  logic [ADDR_BITS-1:0]   araddr;
  logic [7:0]             arlen;
  logic [2:0]             arsize;
  logic [1:0]             arburst;
  logic                   arvalid;
  logic                   arready;
  logic [DATA_BITS-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;
  logic [ADDR_BITS-1:0]   awaddr;
  logic [7:0]             awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;
  logic                   awvalid;
  logic                   awready;
  logic [DATA_BITS-1:0]   wdata;
  logic [DATA_BITS/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/l2_axi_bridge.sv
// L2 external block port to AXI4 master bridge.
// Each L2 block request becomes one INCR burst of SUBBLOCKS beats.
// Writes are captured into a one-block buffer before the burst starts;
// read beats are forwarded to the L2 one cycle after each R handshake.
// One request outstanding at a time.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   addrD, enD, weD        block request from L2 (enD held until accepted)
//   doutDstrobe, doutD     write subblock index / data from L2
//   dinDstrobe, dinD       read subblock index / data to L2
//   readyD                 pulse: read subblock valid / write completed
//   accR, accW             pulse: read / write request accepted
//   err                    sticky: bad RRESP/BRESP or RLAST mismatch
//   m_axi                  AXI4 master port
module l2_axi_bridge #(
  parameter int ADDR_BITS  = 32,
  parameter int BLOCK_BITS = 512,
  parameter int SUBBLOCKS  = 4,
  localparam int SUB_W     = BLOCK_BITS / SUBBLOCKS,
  localparam int SLOG      = $clog2(SUBBLOCKS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] addrD,
  input  logic                 enD,
  input  logic                 weD,
  input  logic [SLOG-1:0]      doutDstrobe,
  input  logic [SUB_W-1:0]     doutD,
  output logic [SLOG-1:0]      dinDstrobe,
  output logic [SUB_W-1:0]     dinD,
  output logic                 readyD,
  output logic                 accR,
  output logic                 accW,
  output logic                 err,
  l2_axi_bridge_if.master      m_axi
);

  localparam int OFFS = $clog2(BLOCK_BITS / 8);
  localparam logic [ADDR_BITS-1:0] OFF_MASK = ADDR_BITS'((64'd1 << OFFS) - 64'd1);
  localparam logic [SLOG-1:0] LAST = SLOG'(SUBBLOCKS - 1);

  typedef enum logic [2:0] {IDLE, WCAP, WXFER, WRESP, RADDR, RDATA} state_t;

  state_t                 state_q, state_n;
  logic [ADDR_BITS-1:0]   addr_q, addr_n;
  logic [SLOG-1:0]        cnt_q, cnt_n;
  logic [SLOG-1:0]        wcnt_q, wcnt_n;
  logic                   aw_done_q, aw_done_n;
  logic                   w_done_q, w_done_n;
  logic                   arvalid_q, arvalid_n;
  logic                   rready_q, rready_n;
  logic                   awvalid_q, awvalid_n;
  logic                   wvalid_q, wvalid_n;
  logic                   wlast_q, wlast_n;
  logic [SUB_W-1:0]       wdata_q, wdata_n;
  logic                   bready_q, bready_n;
  logic [SLOG-1:0]        dinDstrobe_n;
  logic [SUB_W-1:0]       dinD_n;
  logic                   readyD_n, accR_n, accW_n, err_n;
  logic                   buf_we;
  logic                   aw_fin, w_fin;
  logic [SUB_W-1:0]       buffer [SUBBLOCKS];

  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = 8'(SUBBLOCKS - 1);
  assign m_axi.arsize  = 3'($clog2(SUB_W / 8));
  assign m_axi.arburst = 2'b01;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = 8'(SUBBLOCKS - 1);
  assign m_axi.awsize  = 3'($clog2(SUB_W / 8));
  assign m_axi.awburst = 2'b01;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wlast_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;

  always_comb begin
    state_n      = state_q;
    addr_n       = addr_q;
    cnt_n        = cnt_q;
    wcnt_n       = wcnt_q;
    aw_done_n    = aw_done_q;
    w_done_n     = w_done_q;
    arvalid_n    = arvalid_q;
    rready_n     = rready_q;
    awvalid_n    = awvalid_q;
    wvalid_n     = wvalid_q;
    wlast_n      = wlast_q;
    wdata_n      = wdata_q;
    bready_n     = bready_q;
    dinD_n       = dinD;
    dinDstrobe_n = dinDstrobe;
    err_n        = err;
    readyD_n     = 1'b0;
    accR_n       = 1'b0;
    accW_n       = 1'b0;
    buf_we       = 1'b0;
    aw_fin       = 1'b0;
    w_fin        = 1'b0;

    case (state_q)
      IDLE: begin
        if (enD) begin
          addr_n = addrD & ~OFF_MASK;
          if (weD) begin
            cnt_n   = '0;
            state_n = WCAP;
          end else begin
            arvalid_n = 1'b1;
            accR_n    = 1'b1;
            state_n   = RADDR;
          end
        end
      end

      WCAP: begin
        if (!enD) begin
          state_n = IDLE;
        end else if (weD && doutDstrobe == cnt_q) begin
          buf_we = 1'b1;
          if (cnt_q == LAST) begin
            // buffer[0] was captured on an earlier edge, so beat 0 is ready now
            accW_n    = 1'b1;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            wlast_n   = 1'b0;
            wdata_n   = buffer[0];
            wcnt_n    = '0;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
            state_n   = WXFER;
          end else begin
            cnt_n = cnt_q + SLOG'(1);
          end
        end
      end

      WXFER: begin
        aw_fin = aw_done_q;
        w_fin  = w_done_q;
        if (awvalid_q && m_axi.awready) begin
          awvalid_n = 1'b0;
          aw_done_n = 1'b1;
          aw_fin    = 1'b1;
        end
        if (wvalid_q && m_axi.wready) begin
          if (wlast_q) begin
            wvalid_n = 1'b0;
            wlast_n  = 1'b0;
            w_done_n = 1'b1;
            w_fin    = 1'b1;
          end else begin
            wcnt_n  = wcnt_q + SLOG'(1);
            wdata_n = buffer[wcnt_n];
            wlast_n = (wcnt_n == LAST);
          end
        end
        if (aw_fin && w_fin) begin
          bready_n = 1'b1;
          state_n  = WRESP;
        end
      end

      WRESP: begin
        if (m_axi.bvalid) begin
          bready_n = 1'b0;
          readyD_n = 1'b1;
          err_n    = err | (m_axi.bresp != 2'b00);
          state_n  = IDLE;
        end
      end

      RADDR: begin
        if (m_axi.arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          cnt_n     = '0;
          state_n   = RDATA;
        end
      end

      RDATA: begin
        if (m_axi.rvalid) begin
          dinD_n       = m_axi.rdata;
          dinDstrobe_n = cnt_q;
          readyD_n     = 1'b1;
          if (m_axi.rresp != 2'b00 || m_axi.rlast != (cnt_q == LAST))
            err_n = 1'b1;
          if (cnt_q == LAST) begin
            rready_n = 1'b0;
            state_n  = IDLE;
          end else begin
            cnt_n = cnt_q + SLOG'(1);
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      wdata_q    <= '0;
      bready_q   <= 1'b0;
      dinD       <= '0;
      dinDstrobe <= '0;
      readyD     <= 1'b0;
      accR       <= 1'b0;
      accW       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_n;
      addr_q     <= addr_n;
      cnt_q      <= cnt_n;
      wcnt_q     <= wcnt_n;
      aw_done_q  <= aw_done_n;
      w_done_q   <= w_done_n;
      arvalid_q  <= arvalid_n;
      rready_q   <= rready_n;
      awvalid_q  <= awvalid_n;
      wvalid_q   <= wvalid_n;
      wlast_q    <= wlast_n;
      wdata_q    <= wdata_n;
      bready_q   <= bready_n;
      dinD       <= dinD_n;
      dinDstrobe <= dinDstrobe_n;
      readyD     <= readyD_n;
      accR       <= accR_n;
      accW       <= accW_n;
      err        <= err_n;
    end
  end

  // Block buffer holds data only; validity is tracked by the FSM.
  always_ff @(posedge clk) begin
    if (buf_we)
      buffer[cnt_q] <= doutD;
  end

endmodule

// File: tb/tb_l2_axi_bridge.sv
// Directed testbench for l2_axi_bridge; the bench acts as the AXI slave.
module tb_l2_axi_bridge;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addrD;
  logic         enD, weD;
  logic [1:0]   doutDstrobe;
  logic [127:0] doutD;
  logic [1:0]   dinDstrobe;
  logic [127:0] dinD;
  logic         readyD, accR, accW, err;

  int total = 0;
  int bad   = 0;

  logic [128:0] wq [$];
  int naw = 0, n_accr = 0, n_accw = 0, n_rdy = 0;
  logic [127:0] rd_data [4];

  localparam logic [127:0] DA = {32{4'hA}};
  localparam logic [127:0] DB = {32{4'hB}};
  localparam logic [127:0] DC = {32{4'hC}};
  localparam logic [127:0] DD = {32{4'hD}};
  localparam logic [127:0] E0 = 128'h1111_0000_0000_0000_0000_0000_0000_0E00;
  localparam logic [127:0] E1 = 128'h2222_0000_0000_0000_0000_0000_0000_0E01;
  localparam logic [127:0] E2 = 128'h3333_0000_0000_0000_0000_0000_0000_0E02;
  localparam logic [127:0] E3 = 128'h4444_0000_0000_0000_0000_0000_0000_0E03;
  localparam logic [127:0] BADD = {32{4'h5}};

  always #5 clk = ~clk;

  l2_axi_bridge_if #(.ADDR_BITS(32), .DATA_BITS(128)) axi ();

  l2_axi_bridge #(.ADDR_BITS(32), .BLOCK_BITS(512), .SUBBLOCKS(4)) dut (
    .clk(clk), .reset(rst), .addrD(addrD), .enD(enD), .weD(weD),
    .doutDstrobe(doutDstrobe), .doutD(doutD), .dinDstrobe(dinDstrobe),
    .dinD(dinD), .readyD(readyD), .accR(accR), .accW(accW), .err(err),
    .m_axi(axi)
  );

  always @(posedge clk) begin
    if (!rst) begin
      if (axi.wvalid && axi.wready) wq.push_back({axi.wlast, axi.wdata});
      if (axi.awvalid && axi.awready) naw++;
      if (accR) n_accr++;
      if (accW) n_accw++;
      if (readyD) n_rdy++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_arvalid"}, axi.arvalid, 1'b0);
    chk({tag, "_rready"},  axi.rready,  1'b0);
    chk({tag, "_awvalid"}, axi.awvalid, 1'b0);
    chk({tag, "_wvalid"},  axi.wvalid,  1'b0);
    chk({tag, "_bready"},  axi.bready,  1'b0);
    chk({tag, "_readyD"},  readyD, 1'b0);
    chk({tag, "_accR"},    accR, 1'b0);
    chk({tag, "_accW"},    accW, 1'b0);
    chk({tag, "_err"},     err, 1'b0);
    chk({tag, "_dinD"},    dinD, 128'h0);
    chk({tag, "_strobe"},  dinDstrobe, 2'd0);
  endtask

  // lm: rlast per beat, em: SLVERR per beat, ea: expected err after each beat
  task automatic read_burst(input logic [31:0] a, input logic [31:0] exp_a,
                            input logic [3:0] lm, input logic [3:0] em, input logic [3:0] ea);
    int a0;
    a0 = n_accr;
    addrD = a; weD = 1'b0; enD = 1'b1; axi.arready = 1'b1;
    tick;
    chk("rd_accR", accR, 1'b1);
    chk("rd_arvalid", axi.arvalid, 1'b1);
    chk("rd_araddr", axi.araddr, exp_a);
    chk("rd_arlen", axi.arlen, 8'd3);
    chk("rd_arsize", axi.arsize, 3'd4);
    chk("rd_arburst", axi.arburst, 2'd1);
    enD = 1'b0;
    tick;
    chk("rd_arvalid_drop", axi.arvalid, 1'b0);
    chk("rd_rready", axi.rready, 1'b1);
    chk("rd_accR_pulse", accR, 1'b0);
    for (int i = 0; i < 4; i++) begin
      axi.rvalid = 1'b1;
      axi.rdata  = rd_data[i];
      axi.rlast  = lm[i];
      axi.rresp  = em[i] ? 2'b10 : 2'b00;
      tick;
      chk($sformatf("rd_readyD%0d", i), readyD, 1'b1);
      chk($sformatf("rd_strobe%0d", i), dinDstrobe, i);
      chk($sformatf("rd_dinD%0d", i), dinD, rd_data[i]);
      chk($sformatf("rd_err%0d", i), err, ea[i]);
    end
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
    chk("rd_rready_end", axi.rready, 1'b0);
    tick;
    chk("rd_readyD_end", readyD, 1'b0);
    chk("rd_accR_count", n_accr - a0, 1);
  endtask

  task automatic write_block(input logic [31:0] a, input logic [31:0] exp_a,
                             input int nstb, input logic [9:0] stbs, input logic [639:0] dats,
                             input logic [511:0] expd, input int aw_delay, input bit wtoggle,
                             input logic [1:0] br, input logic exp_err, input int exp_lat);
    int w0, r0, aw0, lat;
    bit done;
    w0 = n_accw; aw0 = naw; lat = 0; done = 1'b0;
    wq.delete();
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = br;
    addrD = a; weD = 1'b1; enD = 1'b1;
    doutDstrobe = stbs[1:0]; doutD = dats[127:0];
    tick;
    for (int s = 0; s < nstb; s++) begin
      doutDstrobe = stbs[2*s +: 2];
      doutD = dats[128*s +: 128];
      tick;
    end
    chk("wr_accW", accW, 1'b1);
    chk("wr_awvalid", axi.awvalid, 1'b1);
    chk("wr_wvalid", axi.wvalid, 1'b1);
    chk("wr_wdata0", axi.wdata, expd[127:0]);
    chk("wr_wlast0", axi.wlast, 1'b0);
    chk("wr_wstrb", axi.wstrb, 16'hFFFF);
    chk("wr_awaddr", axi.awaddr, exp_a);
    chk("wr_awlen", axi.awlen, 8'd3);
    chk("wr_awsize", axi.awsize, 3'd4);
    chk("wr_awburst", axi.awburst, 2'd1);
    enD = 1'b0;
    r0 = n_rdy;
    for (int n = 1; n <= 60; n++) begin
      axi.awready = (n > aw_delay);
      axi.wready  = wtoggle ? n[0] : 1'b1;
      if (axi.bready) axi.bvalid = 1'b1;
      tick;
      if (readyD) begin
        done = 1'b1;
        lat = n;
        break;
      end
    end
    chk("wr_done", done, 1'b1);
    chk("wr_bready_drop", axi.bready, 1'b0);
    chk("wr_err", err, exp_err);
    if (exp_lat > 0) chk("wr_latency", lat, exp_lat);
    axi.bvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0; axi.bresp = 2'b00;
    tick;
    chk("wr_readyD_end", readyD, 1'b0);
    chk("wr_readyD_count", n_rdy - r0, 1);
    chk("wr_accW_count", n_accw - w0, 1);
    chk("wr_aw_count", naw - aw0, 1);
    chk("wr_beats", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      chk($sformatf("wr_wdata%0d", i), wq[i][127:0], expd[128*i +: 128]);
      chk($sformatf("wr_wlast%0d", i), wq[i][128], (i == 3));
    end
  endtask

  initial begin
    rd_data[0] = 128'h0123_4567_89AB_CDEF_0000_0000_0000_0D00;
    rd_data[1] = 128'hFEDC_BA98_7654_3210_0000_0000_0000_0D01;
    rd_data[2] = 128'h5A5A_5A5A_A5A5_A5A5_0000_0000_0000_0D02;
    rd_data[3] = 128'hDEAD_BEEF_CAFE_F00D_0000_0000_0000_0D03;
    addrD = '0; enD = 1'b0; weD = 1'b0; doutDstrobe = '0; doutD = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    chk_idle("reset");

    // Read with always-ready slave
    read_burst(32'h0001_0988, 32'h0001_0980, 4'b1000, 4'b0000, 4'b0000);

    // Write A..D, awready after 5 cycles, wready toggling
    write_block(32'h0002_0044, 32'h0002_0040, 4, {2'd3, 2'd2, 2'd1, 2'd0},
                {128'h0, DD, DC, DB, DA}, {DD, DC, DB, DA}, 5, 1'b1, 2'b00, 1'b0, 0);

    // Strobe sequence 0,2,1,2,3: first 2 ignored; ready slave gives minimum latency
    write_block(32'h0002_1000, 32'h0002_1000, 5, {2'd3, 2'd2, 2'd1, 2'd2, 2'd0},
                {E3, E2, E1, BADD, E0}, {E3, E2, E1, E0}, 0, 1'b0, 2'b00, 1'b0, 5);

    // enD dropped after two captured subblocks
    begin
      int w0, r0, aw0;
      w0 = n_accw; r0 = n_rdy; aw0 = naw;
      addrD = 32'h0002_2000; weD = 1'b1; enD = 1'b1; doutDstrobe = 2'd0; doutD = DA;
      tick;
      tick;
      doutDstrobe = 2'd1; doutD = DB;
      tick;
      enD = 1'b0;
      tick;
      axi.awready = 1'b1; axi.wready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick;
        chk("abort_awvalid", axi.awvalid, 1'b0);
        chk("abort_wvalid", axi.wvalid, 1'b0);
      end
      axi.awready = 1'b0; axi.wready = 1'b0;
      chk("abort_accW", n_accw - w0, 0);
      chk("abort_readyD", n_rdy - r0, 0);
      chk("abort_aw", naw - aw0, 0);
      read_burst(32'h0003_0FFF, 32'h0003_0FC0, 4'b1000, 4'b0000, 4'b0000);
    end

    // SLVERR on beat 2, then early rlast on beat 1: err sticks
    read_burst(32'h0004_0000, 32'h0004_0000, 4'b1000, 4'b0100, 4'b1100);
    read_burst(32'h0004_0040, 32'h0004_0040, 4'b1010, 4'b0000, 4'b1111);

    // Reset in the middle of RDATA
    addrD = 32'h0005_0000; weD = 1'b0; enD = 1'b1; axi.arready = 1'b1;
    tick;
    enD = 1'b0;
    tick;
    axi.rvalid = 1'b1; axi.rdata = rd_data[0]; axi.rlast = 1'b0;
    tick;
    chk("midrd_readyD", readyD, 1'b1);
    chk("midrd_err_before", err, 1'b1);
    axi.rvalid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_idle("midrd_reset");

    // Early rlast alone sets err
    read_burst(32'h0005_0100, 32'h0005_0100, 4'b0010, 4'b0000, 4'b1110);

    // Reset in the middle of WXFER
    axi.awready = 1'b0; axi.wready = 1'b0;
    addrD = 32'h0006_0000; weD = 1'b1; enD = 1'b1; doutDstrobe = 2'd0; doutD = DA;
    tick;
    for (int s = 0; s < 4; s++) begin
      doutDstrobe = 2'(s);
      doutD = DA;
      tick;
    end
    chk("midwr_accW", accW, 1'b1);
    enD = 1'b0;
    tick;
    chk("midwr_awvalid", axi.awvalid, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_idle("midwr_reset");

    // BRESP error on a write
    write_block(32'h0007_0020, 32'h0007_0000, 4, {2'd3, 2'd2, 2'd1, 2'd0},
                {128'h0, E3, E2, E1, E0}, {E3, E2, E1, E0}, 0, 1'b0, 2'b10, 1'b1, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
